// File: rtl/data_mem_unit_if.sv
// MEM-stage access bus between the CPU pipeline and the data memory.
interface data_mem_unit_if;
    logic [63:0] address;
    logic        MemWrite;
    logic        MemRead;
    logic [3:0]  xfer_size;
    logic [63:0] write_data;
    logic [63:0] read_data;

    modport master (
        output address, MemWrite, MemRead, xfer_size, write_data,
        input  read_data
    );

    modport slave (
        input  address, MemWrite, MemRead, xfer_size, write_data,
        output read_data
    );
endinterface

// File: rtl/data_mem_unit.sv
// Byte-addressed 64-bit-word data memory with post-reset self-clear,
// sticky illegal-access capture and load/store counters.
module data_mem_unit #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_unit_if.slave  bus,
    output logic            busy,
    output logic            fault,
    output logic [63:0]     fault_addr,
    output logic [31:0]     rd_count,
    output logic [31:0]     wr_count
);
    localparam int unsigned WORD_AW = ADDR_WIDTH - 3;
    localparam int unsigned WORDS   = 1 << WORD_AW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic [WORD_AW-1:0] clear_ptr;
    logic [WORD_AW-1:0] clear_ptr_nxt;
    logic [63:0]        mem [WORDS];

    logic [63:0]        size_mask;
    logic               size_ok;
    logic               misaligned;
    logic               out_of_range;
    logic               active;
    logic               illegal;
    logic               acc_load;
    logic               acc_store;
    logic [WORD_AW-1:0] word_idx;
    logic [5:0]         shift;
    logic [63:0]        wr_mask;
    logic [63:0]        wr_bits;

    // Access decode: size legality, alignment, range and strobe conflicts.
    always_comb begin
        size_mask  = '0;
        size_ok    = 1'b1;
        misaligned = 1'b0;
        case (bus.xfer_size)
            4'b0001: size_mask = 64'h0000_0000_0000_00FF;
            4'b0010: begin
                size_mask  = 64'h0000_0000_0000_FFFF;
                misaligned = bus.address[0];
            end
            4'b0100: begin
                size_mask  = 64'h0000_0000_FFFF_FFFF;
                misaligned = |bus.address[1:0];
            end
            4'b1000: begin
                size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
                misaligned = |bus.address[2:0];
            end
            default: size_ok = 1'b0;
        endcase
        out_of_range = (bus.address >> ADDR_WIDTH) != 64'd0;
        word_idx     = bus.address[ADDR_WIDTH-1:3];
        shift        = {bus.address[2:0], 3'b000};
        active       = (bus.MemRead || bus.MemWrite) && (state == ST_RUN) && reset;
        illegal      = active && (!size_ok || misaligned || out_of_range ||
                                  (bus.MemRead && bus.MemWrite));
        acc_load     = active && !illegal && bus.MemRead;
        acc_store    = active && !illegal && bus.MemWrite;
        wr_mask      = size_mask << shift;
        wr_bits      = (bus.write_data & size_mask) << shift;
    end

    assign bus.read_data = acc_load ? ((mem[word_idx] >> shift) & size_mask) : 64'd0;
    assign busy          = (state == ST_CLEAR) || !reset;

    // Clear sequencer: one word per edge, then hand over to normal operation.
    always_comb begin
        state_nxt     = state;
        clear_ptr_nxt = clear_ptr;
        case (state)
            ST_CLEAR: begin
                clear_ptr_nxt = clear_ptr + WORD_AW'(1);
                if (clear_ptr == WORD_AW'(WORDS - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
        end else begin
            state     <= state_nxt;
            clear_ptr <= clear_ptr_nxt;
        end
    end

    // Storage is untouched by reset itself; only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == ST_CLEAR) begin
                mem[clear_ptr] <= 64'd0;
            end else if (acc_store) begin
                mem[word_idx] <= (mem[word_idx] & ~wr_mask) | wr_bits;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fault      <= 1'b0;
            fault_addr <= 64'd0;
            rd_count   <= 32'd0;
            wr_count   <= 32'd0;
        end else begin
            if (illegal && !fault) begin
                fault      <= 1'b1;
                fault_addr <= bus.address;
            end
            if (acc_load) begin
                rd_count <= rd_count + 32'd1;
            end
            if (acc_store) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: a byte-array reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_data_mem_unit;
    localparam int unsigned AW    = 10;
    localparam int unsigned WORDS = 128;
    localparam int unsigned BYTES = 1024;

    typedef struct {
        logic [63:0] rdata;
        logic        busy;
        logic        fault;
        logic [63:0] faddr;
        logic [31:0] rc;
        logic [31:0] wc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        busy;
    logic        fault;
    logic [63:0] fault_addr;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    data_mem_unit_if bus ();

    data_mem_unit #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .fault      (fault),
        .fault_addr (fault_addr),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t q [$];

    // Reference model state
    logic [7:0]  mem_m [BYTES];
    int          clear_left;
    logic        f_m;
    logic [63:0] fa_m;
    logic [31:0] rc_m;
    logic [31:0] wc_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_acc(input bit rd, input bit wr, input logic [3:0] sz,
                                     input logic [63:0] a);
        if (!(sz == 4'd1 || sz == 4'd2 || sz == 4'd4 || sz == 4'd8)) return 1'b0;
        if ((a % 64'(sz)) != 64'd0) return 1'b0;
        if (a >= 64'(BYTES)) return 1'b0;
        if (rd && wr) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] model_load(input logic [3:0] sz, input logic [63:0] a);
        logic [63:0] v = 64'd0;
        for (int b = 0; b < int'(sz); b++) begin
            v = v | (64'(mem_m[int'(a) + b]) << (8 * b));
        end
        return v;
    endfunction

    // One bus cycle: drive, queue the prediction, advance the model across the edge.
    task automatic step(input bit rst, input bit rd, input bit wr, input logic [3:0] sz,
                        input logic [63:0] a, input logic [63:0] wd);
        exp_t e;
        bit   act;
        bit   ok;
        reset          = rst;
        bus.MemRead    = rd;
        bus.MemWrite   = wr;
        bus.xfer_size  = sz;
        bus.address    = a;
        bus.write_data = wd;
        act     = (rd || wr) && rst && (clear_left == 0);
        ok      = act && legal_acc(rd, wr, sz, a);
        e.rdata = (ok && rd) ? model_load(sz, a) : 64'd0;
        e.busy  = !rst || (clear_left != 0);
        e.fault = f_m;
        e.faddr = fa_m;
        e.rc    = rc_m;
        e.wc    = wc_m;
        q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            clear_left = WORDS;
            f_m  = 1'b0;
            fa_m = 64'd0;
            rc_m = 32'd0;
            wc_m = 32'd0;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h00;
            end
        end else if (act) begin
            if (!ok) begin
                if (!f_m) begin
                    f_m  = 1'b1;
                    fa_m = a;
                end
            end else if (rd) begin
                rc_m = rc_m + 32'd1;
            end else begin
                wc_m = wc_m + 32'd1;
                for (int b = 0; b < int'(sz); b++) mem_m[int'(a) + b] = wd[8*b +: 8];
            end
        end
        #1;
    endtask

    task automatic rand_op(output bit rd, output bit wr, output logic [3:0] sz,
                           output logic [63:0] a, output logic [63:0] wd);
        int k;
        int lim;
        int r;
        k   = $urandom_range(0, 3);
        sz  = 4'(1 << k);
        lim = $urandom_range(0, 1) ? (128 >> k) - 1 : (BYTES >> k) - 1;
        a   = 64'($urandom_range(0, lim)) * 64'(1 << k);
        wd  = {$urandom, $urandom};
        rd  = $urandom_range(0, 1) == 1;
        wr  = !rd;
        r   = $urandom_range(0, 59);
        case (r)
            0: a  = a + 64'd1;
            1: sz = 4'b0110;
            2: a  = a | 64'h0000_0100_0000_0000;
            3: begin rd = 1'b1; wr = 1'b1; end
            4, 5: begin rd = 1'b0; wr = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'd8, 64'd0, 64'd0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd8, 64'd0, 64'd0);
    endtask

    // Runs random (ignored) traffic while busy and checks the clear length.
    task automatic wait_clear();
        int          n = 0;
        bit          rd;
        bit          wr;
        logic [3:0]  sz;
        logic [63:0] a;
        logic [63:0] wd;
        while (busy === 1'b1 && n < 400) begin
            rand_op(rd, wr, sz, a, wd);
            step(1'b1, rd, wr, sz, a, wd);
            n++;
        end
        chk("clear_len", 64'(n), 64'(WORDS));
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("read_data",  bus.read_data,    e.rdata);
            chk("busy",       64'(busy),        64'(e.busy));
            chk("fault",      64'(fault),       64'(e.fault));
            chk("fault_addr", fault_addr,       e.faddr);
            chk("rd_count",   64'(rd_count),    64'(e.rc));
            chk("wr_count",   64'(wr_count),    64'(e.wc));
        end
    end

    initial begin
        bit          rd;
        bit          wr;
        logic [3:0]  sz;
        logic [63:0] a;
        logic [63:0] wd;
        int          guard;

        reset          = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.xfer_size  = 4'd8;
        bus.address    = 64'd0;
        bus.write_data = 64'd0;
        clear_left     = WORDS;
        f_m            = 1'b0;
        fa_m           = 64'd0;
        rc_m           = 32'd0;
        wc_m           = 32'd0;
        for (int i = 0; i < BYTES; i++) mem_m[i] = 8'hXX;
        @(posedge clk);
        #1;

        // Reset, clear length, first load and counter
        do_reset(3);
        wait_clear();
        step(1'b1, 1'b1, 1'b0, 4'd8, 64'h3F8, 64'd0);
        idle(1);

        // Byte-lane merge
        step(1'b1, 1'b0, 1'b1, 4'd8, 64'h10, 64'h1122_3344_5566_7788);
        step(1'b1, 1'b0, 1'b1, 4'd1, 64'h13, 64'h0000_0000_0000_00AB);
        step(1'b1, 1'b1, 1'b0, 4'd8, 64'h10, 64'd0);
        step(1'b1, 1'b1, 1'b0, 4'd2, 64'h12, 64'd0);

        // Misaligned store, then out-of-range load keeps first fault address
        step(1'b1, 1'b0, 1'b1, 4'd4, 64'h22, 64'hDEAD_BEEF_CAFE_F00D);
        step(1'b1, 1'b1, 1'b0, 4'd8, 64'h20, 64'd0);
        step(1'b1, 1'b1, 1'b0, 4'd8, 64'h400, 64'd0);
        idle(1);

        // Illegal size encoding
        do_reset(1);
        wait_clear();
        step(1'b1, 1'b1, 1'b0, 4'b0011, 64'h40, 64'd0);
        idle(1);

        // Double strobe: fault, no write, no count
        do_reset(1);
        wait_clear();
        step(1'b1, 1'b1, 1'b1, 4'd8, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 1'b1, 1'b0, 4'd8, 64'h8, 64'd0);
        idle(1);

        // Reset in the middle of the clear sequence restarts it
        do_reset(1);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b1, 4'd8, 64'h0, 64'h1);
        do_reset(1);
        wait_clear();
        idle(1);

        // Mid-run reset discards the store on the reset edge
        step(1'b1, 1'b0, 1'b1, 4'd8, 64'h30, 64'h0123_4567_89AB_CDEF);
        step(1'b0, 1'b0, 1'b1, 4'd8, 64'h30, 64'hFFFF_0000_FFFF_0000);
        wait_clear();
        step(1'b1, 1'b1, 1'b0, 4'd8, 64'h30, 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            rand_op(rd, wr, sz, a, wd);
            step(1'b1, rd, wr, sz, a, wd);
        end
        idle(2);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Byte-addressed data memory that sits directly downstream of the pipelined CPU's MEM stage. It consumes the MEM-stage address, MemWrite, MemRead, mem_xfer_size and write data, and returns read data in the same cycle for capture into MEM/WB. After every reset it runs a self-clear sequence, and it flags illegal accesses in a sticky fault register. It also keeps read and write access counters for the bench and for debug.

## Interface
- ADDR_WIDTH, 10: byte-address bits backed by storage, giving 2^ADDR_WIDTH bytes organised as 2^(ADDR_WIDTH-3) 64-bit words; legal range is ADDR_WIDTH 4..16.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; reset is asserted while low and sampled on the clk rising edge.
- address  input  64  byte address (CPU MEM_Address).
- MemWrite  input  1  store request.
- MemRead  input  1  load request.
- xfer_size  input  4  transfer size: 4'b0001 = 1 byte, 4'b0010 = 2 bytes, 4'b0100 = 4 bytes, 4'b1000 = 8 bytes; all other values are illegal.
- write_data  input  64  store data; the low size×8 bits are used.
- read_data  output  64  load data, zero-extended, little-endian, combinational.
- busy  output  1  high while the clear sequence runs or reset is asserted; top level holds the CPU in reset while busy is high.
- fault  output  1  sticky illegal-access flag.
- fault_addr  output  64  address of the first faulting access.
- rd_count  output  32  number of accepted loads.
- wr_count  output  32  number of accepted stores.

## Operation
- **States.** Two states, CLEAR and RUN. Reset low forces CLEAR, clear_ptr=0, fault=0, fault_addr=0, rd_count=0, wr_count=0.
- **CLEAR.** Each edge with reset high writes 64'h0 to word clear_ptr and increments clear_ptr. On the edge that writes the last word (clear_ptr = 2^(ADDR_WIDTH-3)-1) the state moves to RUN. busy = 1 whenever state is CLEAR.
- **RUN.** busy = 0.
- **Access decode.** An access is active when MemRead or MemWrite is high, state is RUN, and reset is high. An active access is illegal if any of these hold:
  - xfer_size is not one of the four legal encodings;
  - address is not aligned to the transfer size (the low log2(size) bits are non-zero);
  - address[63:ADDR_WIDTH] is non-zero;
  - MemRead and MemWrite are both high.
- **Accepted access.** Active and not illegal.
- **Word/byte selection.** Word index = address[ADDR_WIDTH-1:3]; byte lane = address[2:0].
- **Load.** read_data = the size bytes starting at the byte lane, little-endian, zero-extended to 64 bits. read_data = 0 when the access is not an accepted load, which includes while busy and when illegal.
- **Store.** An accepted store writes only the addressed bytes on the edge; all other bytes in the word are unchanged.
- **Fault capture.** On an illegal access, if fault = 0: fault <= 1 and fault_addr <= address. If fault = 1, nothing changes. An illegal store writes nothing. Requests while busy are ignored: no write, no count, no fault.
- **Counters.** rd_count increments on each accepted load edge, and wr_count on each accepted store edge. Both wrap 2^32-1 -> 0.
- **Reset contents.** Reset does not itself alter storage; the following CLEAR sequence zeroes it.

## Timing
- **Output reset values.** busy=1, fault=0, fault_addr=0, rd_count=0, wr_count=0, read_data=0.
- **Clear duration.** busy deasserts exactly 2^(ADDR_WIDTH-3) edges after the first edge with reset high (128 edges at the default). The first RUN cycle follows immediately.
- **Reset mid-clear.** Returns to CLEAR with clear_ptr=0; the full sequence restarts.
- **Reset mid-RUN.** Any store presented on the reset edge is discarded.
- **Load latency.** Combinational, zero cycles: read_data is valid in the same cycle as address, MemRead and xfer_size.
- **Store latency.** A store is committed on the edge and visible to a load in the next cycle. A load in the same cycle as the store is not possible, because both strobes high is illegal.
- **Fault/counter timing.** fault, fault_addr and the counters update on the edge that ends the offending or accepted cycle.

## Test plan
- **Reset and clear.** Hold reset low for 3 cycles, then release. busy must stay 1 for exactly 128 edges and then drop. A load of 8 bytes at 0x3F8 must return 0. rd_count must read 1 one edge after that load.
- **Byte-lane store/load.** Store 8 bytes 64'h1122334455667788 at 0x10, then store 1 byte 8'hAB at 0x13. An 8-byte load at 0x10 must return 64'h11223344AB667788. A 2-byte load at 0x12 must return 64'h000000000000AB66.
- **Misalignment fault.** A 4-byte store at 0x22 must set fault=1 and fault_addr=0x22, and memory at 0x20 must be unchanged. A later out-of-range load at 0x400 must leave fault_addr at 0x22, and read_data must be 0.
- **Illegal size and double strobe.** xfer_size=4'b0011 must raise fault. After reset and clear, MemRead and MemWrite both high at 0x8 must raise fault, write nothing, and count nothing.
- **Reset mid-clear.** Assert reset for 1 cycle on edge 50 of the clear sequence. busy must then last a further 128 edges after release.
- **Counter wrap and busy gating.** Force wr_count to 32'hFFFFFFFF via 2^32-1 accepted stores (or a bench-level deposit), then perform one more accepted store: wr_count must become 0. Stores issued while busy must not change wr_count.
